io_safety_gate: RTL and testbench

Parametrised fail-safe output gate between the SOPC-driven GPIO/LED nets and the board pins. It supersedes the fixed-function global disable: it forces every output to its per-bit default on any shutdown source (keys, power-management kill switch, future sources). Release is debounced, per-source latching is optional with a software clear, and a power-up/recovery hold-off must expire before outputs are handed back.

---
 rtl/io_safety_pkg.sv | 16 +
 rtl/shutdown_conditioner.sv | 79 +++++++
 rtl/io_safety_gate.sv | 125 ++++++++++++
 tb/tb_io_safety_gate.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_safety_pkg.sv
// Shared types and helpers for the fail-safe output gate.
package io_safety_pkg;

    // Gate FSM encoding; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        ST_SAFE    = 2'b00,
        ST_HOLDOFF = 2'b01,
        ST_RUN     = 2'b10
    } state_e;

    // Bits needed for a counter that must be able to hold the value 'cycles'.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/shutdown_conditioner.sv
// One shutdown source: synchroniser, release debounce and optional latch.
// Assertion passes straight through (act_o follows the synchronised input);
// only the release is filtered.
module shutdown_conditioner
    import io_safety_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit LATCH           = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic shutdown_i,
    input  logic clear_i,
    output logic act_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q;
    logic          s2_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lat_q, lat_d;

    // Two-flop synchroniser for the asynchronous shutdown request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            s2_q    <= 1'b0;
        end else begin
            sync1_q <= shutdown_i;
            s2_q    <= sync1_q;
        end
    end

    // Release debounce: any high sample re-arms the filter, a full quiet run drops it.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (s2_q) begin
            filt_d = 1'b1;
            cnt_d  = '0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_q == CNT_LAST) begin
                filt_d = 1'b0;
            end else begin
                filt_d = filt_q;
            end
        end
    end

    // Latch holds until software clears it, and only once the source is fully quiet.
    always_comb begin
        lat_d = LATCH & (s2_q | (lat_q & ~(clear_i & ~filt_q)));
    end

    // Debounce and latch state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= '0;
            lat_q  <= 1'b0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            lat_q  <= lat_d;
        end
    end

    assign act_o = s2_q | filt_q | lat_q;

endmodule

// File: rtl/io_safety_gate.sv
// Fail-safe output gate: forces every gated output to its safe default while
// any shutdown source is active and for a hold-off period afterwards.
module io_safety_gate
    import io_safety_pkg::*;
#(
    parameter int                NUM_IN          = 3,
    parameter int                NUM_IOS         = 51,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                HOLDOFF_CYCLES  = 5000000,
    parameter logic [NUM_IN-1:0] LATCH_MASK      = {NUM_IN{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IN-1:0]  shutdown,
    input  logic               clear,
    input  logic [NUM_IOS-1:0] gpio_in,
    input  logic [NUM_IOS-1:0] gpio_out_default,
    output logic [NUM_IOS-1:0] gpio_out,
    output logic               tripped,
    output logic [NUM_IN-1:0]  cause,
    output logic [1:0]         state
);

    localparam int HW = cnt_width(HOLDOFF_CYCLES);
    localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLDOFF_CYCLES);

    logic [NUM_IN-1:0]  act_s;
    logic               any_act_s;
    state_e             state_q, state_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [NUM_IN-1:0]  cause_q, cause_d;
    logic [NUM_IOS-1:0] gpio_in_q;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_src
        shutdown_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LATCH           (LATCH_MASK[gi])
        ) u_cond (
            .clk        (clk),
            .reset      (reset),
            .shutdown_i (shutdown[gi]),
            .clear_i    (clear),
            .act_o      (act_s[gi])
        );
    end

    assign any_act_s = |act_s;

    // Next-state logic: any active source forces SAFE; hold-off restarts from zero.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            ST_SAFE: begin
                hcnt_d = '0;
                if (any_act_s) begin
                    state_d = ST_SAFE;
                end else begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (any_act_s) begin
                    state_d = ST_SAFE;
                    hcnt_d  = '0;
                end else begin
                    if (hcnt_q == H_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLDOFF;
                    end
                    if (hcnt_q != H_MAX) begin
                        hcnt_d = hcnt_q + HW'(1);
                    end else begin
                        hcnt_d = hcnt_q;
                    end
                end
            end
            ST_RUN: begin
                if (any_act_s) begin
                    state_d = ST_SAFE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_SAFE;
                hcnt_d  = '0;
            end
        endcase
    end

    // Cause is sticky; a clear only drops bits whose source is no longer active.
    always_comb begin
        cause_d = cause_q;
        if (clear) begin
            cause_d = act_s;
        end else begin
            cause_d = cause_q | act_s;
        end
    end

    // State, hold-off counter, cause record and registered normal-mode outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SAFE;
            hcnt_q    <= '0;
            cause_q   <= '0;
            gpio_in_q <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            cause_q   <= cause_d;
            gpio_in_q <= gpio_in;
        end
    end

    // Output mux is driven by the registered state so reset forces defaults at once.
    assign gpio_out = (state_q == ST_RUN) ? gpio_in_q : gpio_out_default;
    assign tripped  = (state_q != ST_RUN);
    assign cause    = cause_q;
    assign state    = state_q;

endmodule

// File: tb/tb_io_safety_gate.sv
// Scoreboard bench for io_safety_gate with short debounce and hold-off.
module tb_io_safety_gate;

    localparam logic [1:0] S_SAFE    = 2'b00;
    localparam logic [1:0] S_HOLDOFF = 2'b01;
    localparam logic [1:0] S_RUN     = 2'b10;
    localparam logic [7:0] GIN       = 8'hA5;
    localparam logic [7:0] GDEF      = 8'h20;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic [7:0] gout;
        logic       trip;
        logic [2:0] cause;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] shutdown;
    logic       clear;
    logic [7:0] gpio_in;
    logic [7:0] gpio_out_default;
    logic [7:0] gpio_out;
    logic       tripped;
    logic [2:0] cause;
    logic [1:0] state;

    exp_t sb[$];
    int   cyc;
    int   n_checks;
    int   n_pass;

    io_safety_gate #(
        .NUM_IN          (3),
        .NUM_IOS         (8),
        .DEBOUNCE_CYCLES (4),
        .HOLDOFF_CYCLES  (8),
        .LATCH_MASK      (3'b100)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .shutdown         (shutdown),
        .clear            (clear),
        .gpio_in          (gpio_in),
        .gpio_out_default (gpio_out_default),
        .gpio_out         (gpio_out),
        .tripped          (tripped),
        .cause            (cause),
        .state            (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    // Queue expectations for absolute cycles from..to.
    task automatic push_range(input int from, input int to, input logic [1:0] st, input logic [2:0] c);
        exp_t e;
        for (int i = from; i <= to; i++) begin
            e.cyc   = i;
            e.st    = st;
            e.gout  = (st == S_RUN) ? GIN : GDEF;
            e.trip  = (st != S_RUN);
            e.cause = c;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        int   base;
        exp_t e;
        repeat (3) tick();
        n_checks++;
        if ({state, gpio_out, tripped, cause} !== {S_SAFE, GDEF, 1'b1, 3'b000}) begin
            $display("FAIL reset_hold: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=0 gpio_out=20 tripped=1 cause=000",
                     state, gpio_out, tripped, cause);
        end else begin
            n_pass++;
        end
        reset = 1'b0;
        base  = cyc;
        push_range(base + 1, base + 8, S_HOLDOFF, 3'b000);
        push_range(base + 9, base + 10, S_RUN, 3'b000);
        for (int t = 1; t <= 10; t++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL powerup cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    task automatic test_pulse();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 7, S_SAFE, 3'b001);
        push_range(base + 8, base + 15, S_HOLDOFF, 3'b001);
        push_range(base + 16, base + 16, S_RUN, 3'b001);
        push_range(base + 17, base + 17, S_RUN, 3'b000);
        for (int t = 1; t <= 17; t++) begin
            shutdown = 3'b000;
            shutdown[0] = (t == 1);
            clear = (t == 17);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL pulse cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_debounce();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 43, S_SAFE, 3'b010);
        push_range(base + 44, base + 51, S_HOLDOFF, 3'b010);
        push_range(base + 52, base + 52, S_RUN, 3'b010);
        push_range(base + 53, base + 53, S_RUN, 3'b000);
        for (int t = 1; t <= 53; t++) begin
            shutdown = 3'b000;
            shutdown[1] = (t <= 40) && (((t - 1) % 4) == 0);
            clear = (t == 53);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL debounce cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_latch();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 40, S_SAFE, 3'b100);
        push_range(base + 41, base + 48, S_HOLDOFF, 3'b100);
        push_range(base + 49, base + 49, S_RUN, 3'b100);
        push_range(base + 50, base + 50, S_RUN, 3'b000);
        for (int t = 1; t <= 50; t++) begin
            shutdown = 3'b000;
            shutdown[2] = (t == 1) || ((t >= 20) && (t <= 30));
            clear = (t == 25) || (t == 40) || (t == 50);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL latch cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_holdoff_abort();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 7, S_SAFE, 3'b001);
        push_range(base + 8, base + 13, S_HOLDOFF, 3'b001);
        push_range(base + 14, base + 18, S_SAFE, 3'b001);
        push_range(base + 19, base + 26, S_HOLDOFF, 3'b001);
        push_range(base + 27, base + 27, S_RUN, 3'b001);
        push_range(base + 28, base + 28, S_RUN, 3'b000);
        for (int t = 1; t <= 28; t++) begin
            shutdown = 3'b000;
            shutdown[0] = (t == 1) || (t == 12);
            clear = (t == 28);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL holdoff_abort cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_reset_midrun();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 7, S_SAFE, 3'b001);
        push_range(base + 8, base + 15, S_HOLDOFF, 3'b001);
        push_range(base + 16, base + 18, S_RUN, 3'b001);
        for (int t = 1; t <= 18; t++) begin
            shutdown = 3'b000;
            shutdown[0] = (t == 1);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL reset_midrun cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({state, gpio_out, tripped, cause} !== {S_SAFE, GDEF, 1'b1, 3'b000}) begin
            $display("FAIL reset_async: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=0 gpio_out=20 tripped=1 cause=000",
                     state, gpio_out, tripped, cause);
        end else begin
            n_pass++;
        end
        repeat (2) tick();
        reset = 1'b0;
        base  = cyc;
        push_range(base + 1, base + 8, S_HOLDOFF, 3'b000);
        push_range(base + 9, base + 10, S_RUN, 3'b000);
        for (int t = 1; t <= 10; t++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL reset_recover cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    task automatic test_latch_reset();
        int   base;
        exp_t e;
        base = cyc;
        push_range(base + 1, base + 2, S_RUN, 3'b000);
        push_range(base + 3, base + 20, S_SAFE, 3'b100);
        for (int t = 1; t <= 20; t++) begin
            shutdown = 3'b000;
            shutdown[2] = (t == 1);
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL latch_reset cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({state, gpio_out, tripped, cause} !== {S_SAFE, GDEF, 1'b1, 3'b000}) begin
            $display("FAIL latch_reset_async: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=0 gpio_out=20 tripped=1 cause=000",
                     state, gpio_out, tripped, cause);
        end else begin
            n_pass++;
        end
        repeat (2) tick();
        reset = 1'b0;
        base  = cyc;
        push_range(base + 1, base + 8, S_HOLDOFF, 3'b000);
        push_range(base + 9, base + 10, S_RUN, 3'b000);
        for (int t = 1; t <= 10; t++) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if ({state, gpio_out, tripped, cause} !== {e.st, e.gout, e.trip, e.cause}) begin
                    $display("FAIL latch_discard cyc=%0d: got state=%0d gpio_out=%h tripped=%b cause=%b, expected state=%0d gpio_out=%h tripped=%b cause=%b",
                             cyc, state, gpio_out, tripped, cause, e.st, e.gout, e.trip, e.cause);
                end else begin
                    n_pass++;
                end
            end
        end
    endtask

    initial begin
        cyc              = 0;
        n_checks         = 0;
        n_pass           = 0;
        reset            = 1'b1;
        shutdown         = 3'b000;
        clear            = 1'b0;
        gpio_in          = GIN;
        gpio_out_default = GDEF;

        test_reset();
        test_pulse();
        test_debounce();
        test_latch();
        test_holdoff_abort();
        test_reset_midrun();
        test_latch_reset();

        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
